// File: rtl/sram_ctrl_pkg.sv
// Shared types and constants for the async SRAM controller (512K x 8, 25 ns part).
package sram_ctrl_pkg;

    localparam int unsigned ADDR_W = 19;
    localparam int unsigned DATA_W = 8;

    // SRAM datasheet timing, in ns: address access, write pulse width, output-disable.
    localparam int unsigned T_AA_NS  = 25;
    localparam int unsigned T_PWE_NS = 15;
    localparam int unsigned T_HZ_NS  = 8;

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        TURN     = 3'd1,
        RD       = 3'd2,
        WR_SETUP = 3'd3,
        WR_PULSE = 3'd4,
        WR_HOLD  = 3'd5
    } state_t;

    // Width of the shared RD / WR_PULSE down-counter.
    function automatic int unsigned cnt_width(input int unsigned rd, input int unsigned wr);
        return $clog2(((rd > wr) ? rd : wr) + 1);
    endfunction

endpackage

// File: rtl/sram_ctrl_if.sv
// Requester-side req/ack bus of the SRAM controller.
interface sram_ctrl_if;
    import sram_ctrl_pkg::*;

    logic              bus_req;
    logic              bus_wr;
    logic [ADDR_W-1:0] bus_addr;
    logic [DATA_W-1:0] bus_wrdata;
    logic [DATA_W-1:0] bus_rddata;
    logic              bus_ack;

    modport master (
        output bus_req, bus_wr, bus_addr, bus_wrdata,
        input  bus_rddata, bus_ack
    );

    modport slave (
        input  bus_req, bus_wr, bus_addr, bus_wrdata,
        output bus_rddata, bus_ack
    );

endinterface

// File: rtl/sram_ctrl.sv
// Bus-to-async-SRAM controller: one byte read or write per req/ack transaction,
// with cycle-counted setup/pulse/hold on CE_n/OE_n/WE_n. All outputs registered.
module sram_ctrl
    import sram_ctrl_pkg::*;
#(
    parameter int unsigned RD_CYCLES = 2,
    parameter int unsigned WR_CYCLES = 1
) (
    input  logic              clk,
    input  logic              reset,
    sram_ctrl_if.slave        bus,
    output logic [ADDR_W-1:0] sram_a,
    output logic [DATA_W-1:0] sram_dq_out,
    output logic              sram_dq_oe,
    input  logic [DATA_W-1:0] sram_dq_in,
    output logic              sram_ce_n,
    output logic              sram_oe_n,
    output logic              sram_we_n
);

    localparam int unsigned CNT_W = cnt_width(RD_CYCLES, WR_CYCLES);
    localparam logic [CNT_W-1:0] RD_INIT = CNT_W'(RD_CYCLES - 1);
    localparam logic [CNT_W-1:0] WR_INIT = CNT_W'(WR_CYCLES - 1);

    state_t            state;
    logic [CNT_W-1:0]  cnt;
    logic              last_was_read;
    logic              ack_q;
    logic [DATA_W-1:0] rddata_q;

    assign bus.bus_ack    = ack_q;
    assign bus.bus_rddata = rddata_q;

    // Control FSM; every SRAM pin and bus output is a register set here.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state         <= IDLE;
            cnt           <= '0;
            last_was_read <= 1'b0;
            ack_q         <= 1'b0;
            rddata_q      <= '0;
            sram_a        <= '0;
            sram_dq_out   <= '0;
            sram_dq_oe    <= 1'b0;
            sram_ce_n     <= 1'b1;
            sram_oe_n     <= 1'b1;
            sram_we_n     <= 1'b1;
        end else begin
            ack_q <= 1'b0;
            case (state)
                IDLE: begin
                    // The ack cycle never re-accepts, even with bus_req still high.
                    if (bus.bus_req && !ack_q) begin
                        sram_a      <= bus.bus_addr;
                        sram_dq_out <= bus.bus_wrdata;
                        if (!bus.bus_wr) begin
                            state     <= RD;
                            cnt       <= RD_INIT;
                            sram_ce_n <= 1'b0;
                            sram_oe_n <= 1'b0;
                        end else if (last_was_read) begin
                            state <= TURN;
                        end else begin
                            state      <= WR_SETUP;
                            sram_ce_n  <= 1'b0;
                            sram_dq_oe <= 1'b1;
                        end
                    end
                end
                TURN: begin
                    // Extra dead cycle lets the SRAM release the IO after a read.
                    state      <= WR_SETUP;
                    sram_ce_n  <= 1'b0;
                    sram_dq_oe <= 1'b1;
                end
                RD: begin
                    if (cnt == '0) begin
                        state         <= IDLE;
                        rddata_q      <= sram_dq_in;
                        ack_q         <= 1'b1;
                        last_was_read <= 1'b1;
                        sram_ce_n     <= 1'b1;
                        sram_oe_n     <= 1'b1;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                WR_SETUP: begin
                    state     <= WR_PULSE;
                    cnt       <= WR_INIT;
                    sram_we_n <= 1'b0;
                end
                WR_PULSE: begin
                    if (cnt == '0) begin
                        state     <= WR_HOLD;
                        sram_we_n <= 1'b1;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                WR_HOLD: begin
                    state         <= IDLE;
                    ack_q         <= 1'b1;
                    last_was_read <= 1'b0;
                    sram_ce_n     <= 1'b1;
                    sram_dq_oe    <= 1'b0;
                end
                default: begin
                    state      <= IDLE;
                    sram_ce_n  <= 1'b1;
                    sram_oe_n  <= 1'b1;
                    sram_we_n  <= 1'b1;
                    sram_dq_oe <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sram_ctrl.sv
// Directed and random bench for sram_ctrl with a behavioural async SRAM.
`timescale 1ns/1ps
module tb_sram_ctrl;
    import sram_ctrl_pkg::*;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [18:0] sram_a;
    logic [7:0]  sram_dq_out;
    logic [7:0]  sram_dq_in;
    logic        sram_dq_oe, sram_ce_n, sram_oe_n, sram_we_n;

    int total = 0;
    int bad = 0;
    int viol_mem = 0;
    int viol_mon = 0;
    bit mon_en = 1'b0;
    bit last_rd = 1'b0;

    logic [7:0] sram_mem [0:524287];
    logic [7:0] ref_mem  [0:524287];

    sram_ctrl_if bus ();

    sram_ctrl #(.RD_CYCLES(2), .WR_CYCLES(1)) dut (
        .clk         (clk),
        .reset       (reset),
        .bus         (bus),
        .sram_a      (sram_a),
        .sram_dq_out (sram_dq_out),
        .sram_dq_oe  (sram_dq_oe),
        .sram_dq_in  (sram_dq_in),
        .sram_ce_n   (sram_ce_n),
        .sram_oe_n   (sram_oe_n),
        .sram_we_n   (sram_we_n)
    );

    // 35 ns clock
    always #17.5 clk = ~clk;

    // SRAM read path
    assign sram_dq_in = (!sram_ce_n && !sram_oe_n) ? sram_mem[sram_a] : 8'hxx;

    // SRAM write: commit on WE_n rising, check pulse width and bus drive
    realtime t_we_fall = 0.0;
    always @(negedge sram_we_n) t_we_fall = $realtime;
    always @(posedge sram_we_n) begin
        if (!reset && sram_ce_n === 1'b0) begin
            if ($realtime - t_we_fall < real'(T_PWE_NS)) viol_mem++;
            if (sram_dq_oe) sram_mem[sram_a] = sram_dq_out;
            else viol_mem++;
        end
    end

    // Pin invariants sampled on the falling edge
    logic [18:0] p_a;
    logic [7:0]  p_d;
    logic        p_ce, p_oe;
    always @(negedge clk) begin
        if (mon_en) begin
            if (!sram_oe_n && !sram_we_n) viol_mon++;
            if (sram_dq_oe && !sram_oe_n) viol_mon++;
            if (sram_dq_oe && !p_oe) viol_mon++;
            if ((sram_a !== p_a || sram_dq_out !== p_d) && !p_ce) viol_mon++;
        end
        p_a  = sram_a;
        p_d  = sram_dq_out;
        p_ce = sram_ce_n;
        p_oe = sram_oe_n;
    end

    task automatic do_op(input bit wr, input logic [18:0] a, input logic [7:0] d,
                         output logic [7:0] rd, output int lat, output int we_lo,
                         output int oe_lo, output int dq_hi);
        int guard;
        guard = 0;
        @(negedge clk);
        while (bus.bus_ack && guard < 10) begin
            @(negedge clk);
            guard++;
        end
        bus.bus_req    = 1'b1;
        bus.bus_wr     = wr;
        bus.bus_addr   = a;
        bus.bus_wrdata = d;
        lat = 0; we_lo = 0; oe_lo = 0; dq_hi = 0;
        @(posedge clk); #1;
        while (1'b1) begin
            if (!sram_we_n) we_lo++;
            if (!sram_oe_n) oe_lo++;
            if (sram_dq_oe) dq_hi++;
            if (bus.bus_ack) break;
            if (lat >= 20) break;
            @(posedge clk); #1;
            lat++;
        end
        rd = bus.bus_rddata;
        bus.bus_req = 1'b0;
        if (wr) ref_mem[a] = d;
        last_rd = !wr;
    endtask

    task automatic test_reset();
        bus.bus_req = 1'b0; bus.bus_wr = 1'b0; bus.bus_addr = '0; bus.bus_wrdata = '0;
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        total++;
        if ({sram_ce_n, sram_oe_n, sram_we_n, sram_dq_oe, bus.bus_ack} !== 5'b11100) begin
            bad++;
            $display("FAIL reset_strobes got=%b want=11100", {sram_ce_n, sram_oe_n, sram_we_n, sram_dq_oe, bus.bus_ack});
        end
        total++;
        if ({sram_a, sram_dq_out, bus.bus_rddata} !== 35'd0) begin
            bad++;
            $display("FAIL reset_regs a=%h dq=%h rd=%h want all 0", sram_a, sram_dq_out, bus.bus_rddata);
        end
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic test_reset_mid_rd();
        bit ack_seen;
        ack_seen = 1'b0;
        @(negedge clk);
        bus.bus_req = 1'b1; bus.bus_wr = 1'b0; bus.bus_addr = 19'h005A8;
        @(posedge clk); #1;
        @(posedge clk); #5;
        reset = 1'b1;
        #1;
        total++;
        if ({sram_ce_n, sram_oe_n, sram_we_n, sram_dq_oe} !== 4'b1110) begin
            bad++;
            $display("FAIL mid_rd_reset_strobes got=%b want=1110", {sram_ce_n, sram_oe_n, sram_we_n, sram_dq_oe});
        end
        bus.bus_req = 1'b0;
        repeat (2) begin
            @(posedge clk); #1;
            if (bus.bus_ack) ack_seen = 1'b1;
        end
        @(negedge clk);
        reset = 1'b0;
        repeat (4) begin
            @(posedge clk); #1;
            if (bus.bus_ack) ack_seen = 1'b1;
        end
        total++;
        if (ack_seen !== 1'b0) begin
            bad++;
            $display("FAIL mid_rd_no_ack got ack_seen=%0d want=0", ack_seen);
        end
        total++;
        if ({sram_ce_n, sram_oe_n, sram_we_n, sram_dq_oe} !== 4'b1110) begin
            bad++;
            $display("FAIL mid_rd_idle_after got=%b want=1110", {sram_ce_n, sram_oe_n, sram_we_n, sram_dq_oe});
        end
        last_rd = 1'b0;
    endtask

    task automatic test_write();
        logic [7:0] rd;
        int lat, we_lo, oe_lo, dq_hi;
        do_op(1'b1, 19'h005A8, 8'hA5, rd, lat, we_lo, oe_lo, dq_hi);
        total++;
        if (lat !== 3) begin bad++; $display("FAIL wr_latency got=%0d want=3", lat); end
        total++;
        if (we_lo !== 1 || dq_hi !== 3 || oe_lo !== 0) begin
            bad++;
            $display("FAIL wr_strobes we_lo=%0d dq_hi=%0d oe_lo=%0d want 1/3/0", we_lo, dq_hi, oe_lo);
        end
        total++;
        if (sram_mem[19'h005A8] !== 8'hA5 || viol_mem !== 0) begin
            bad++;
            $display("FAIL wr_sram_cell got=%h viol=%0d want=a5/0", sram_mem[19'h005A8], viol_mem);
        end
    endtask

    task automatic test_read();
        logic [7:0] rd;
        int lat, we_lo, oe_lo, dq_hi;
        do_op(1'b0, 19'h005A8, 8'h00, rd, lat, we_lo, oe_lo, dq_hi);
        total++;
        if (lat !== 2) begin bad++; $display("FAIL rd_latency got=%0d want=2", lat); end
        total++;
        if (rd !== 8'hA5) begin bad++; $display("FAIL rd_data got=%h want=a5", rd); end
        total++;
        if (oe_lo !== 2 || we_lo !== 0 || dq_hi !== 0) begin
            bad++;
            $display("FAIL rd_strobes oe_lo=%0d we_lo=%0d dq_hi=%0d want 2/0/0", oe_lo, we_lo, dq_hi);
        end
    endtask

    task automatic test_turnaround();
        logic [7:0] rd;
        int lat, we_lo, oe_lo, dq_hi;
        do_op(1'b0, 19'h00000, 8'h00, rd, lat, we_lo, oe_lo, dq_hi);
        total++;
        if (rd !== 8'h00 || lat !== 2) begin bad++; $display("FAIL turn_rd0 data=%h lat=%0d want 00/2", rd, lat); end
        do_op(1'b1, 19'h7FFFF, 8'h3C, rd, lat, we_lo, oe_lo, dq_hi);
        total++;
        if (lat !== 4) begin bad++; $display("FAIL turn_wr_latency got=%0d want=4", lat); end
        total++;
        if (we_lo !== 1 || dq_hi !== 3) begin bad++; $display("FAIL turn_wr_strobes we_lo=%0d dq_hi=%0d want 1/3", we_lo, dq_hi); end
        total++;
        if (viol_mon !== 0) begin bad++; $display("FAIL turn_invariants got=%0d want=0", viol_mon); end
        do_op(1'b0, 19'h7FFFF, 8'h00, rd, lat, we_lo, oe_lo, dq_hi);
        total++;
        if (rd !== 8'h3C || lat !== 2) begin bad++; $display("FAIL turn_readback data=%h lat=%0d want 3c/2", rd, lat); end
    endtask

    task automatic test_back_to_back();
        logic [7:0] rd;
        logic [7:0] got [4];
        int at [4];
        int lat, we_lo, oe_lo, dq_hi, n_ack, edge_n;
        for (int i = 1; i <= 4; i++)
            do_op(1'b1, 19'(i), 8'(i * 8'h11), rd, lat, we_lo, oe_lo, dq_hi);
        @(negedge clk);
        while (bus.bus_ack) @(negedge clk);
        bus.bus_req = 1'b1; bus.bus_wr = 1'b0; bus.bus_addr = 19'h00001;
        n_ack = 0;
        edge_n = 0;
        for (int c = 0; c < 30; c++) begin
            @(posedge clk); #1;
            edge_n++;
            if (bus.bus_ack) begin
                if (n_ack < 4) begin
                    got[n_ack] = bus.bus_rddata;
                    at[n_ack]  = edge_n;
                end
                n_ack++;
                if (n_ack >= 4) bus.bus_req = 1'b0;
                else bus.bus_addr = bus.bus_addr + 19'd1;
            end
        end
        bus.bus_req = 1'b0;
        last_rd = 1'b1;
        total++;
        if (n_ack !== 4) begin bad++; $display("FAIL b2b_ack_count got=%0d want=4", n_ack); end
        for (int i = 0; i < 4; i++) begin
            if (i < n_ack) begin
                total++;
                if (got[i] !== 8'(8'h11 * (i + 1)) || at[i] !== 3 + 4 * i) begin
                    bad++;
                    $display("FAIL b2b_read%0d data=%h edge=%0d want=%h/%0d", i, got[i], at[i], 8'(8'h11 * (i + 1)), 3 + 4 * i);
                end
            end
        end
    endtask

    task automatic test_random();
        logic [7:0] rd, d, exp_d;
        logic [18:0] a;
        bit wr;
        int lat, we_lo, oe_lo, dq_hi, exp_lat;
        for (int i = 0; i < 2000; i++) begin
            wr = 1'($urandom_range(0, 1));
            a  = {($urandom_range(0, 1) != 0) ? 11'h7FF : 11'h000, 8'($urandom_range(0, 255))};
            d  = 8'($urandom);
            exp_d = ref_mem[a];
            exp_lat = wr ? (last_rd ? 4 : 3) : 2;
            repeat ($urandom_range(0, 2)) @(negedge clk);
            do_op(wr, a, d, rd, lat, we_lo, oe_lo, dq_hi);
            total++;
            if (lat !== exp_lat) begin bad++; $display("FAIL rnd_latency op=%0d wr=%0d got=%0d want=%0d", i, wr, lat, exp_lat); end
            if (!wr) begin
                total++;
                if (rd !== exp_d) begin bad++; $display("FAIL rnd_data op=%0d addr=%h got=%h want=%h", i, a, rd, exp_d); end
            end
        end
        total++;
        if (viol_mon !== 0 || viol_mem !== 0) begin
            bad++;
            $display("FAIL rnd_invariants mon=%0d mem=%0d want 0/0", viol_mon, viol_mem);
        end
    endtask

    initial begin
        for (int i = 0; i < 524288; i++) begin
            sram_mem[i] = 8'h00;
            ref_mem[i]  = 8'h00;
        end
        test_reset();
        test_reset_mid_rd();
        mon_en = 1'b1;
        test_write();
        test_read();
        test_turnaround();
        test_back_to_back();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    // Global watchdog
    initial begin
        #20ms;
        $display("FAIL watchdog timeout total=%0d bad=%0d", total, bad);
        $fatal(1, "timeout");
    end

endmodule
